// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared types and constants for the pipeline stall/flush controller.
//   - state_t : controller FSM states
//   - ctrl_t  : the seven non-constant buffer controls, packed MSB-first as
//               pc_go, if_id_go, id_exe_go, exe_mem_go, mem_wb_go,
//               if_id_clear, id_exe_clear
//   - canned control patterns used by the priority mux
package pipeline_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int CNT_W  = 32;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_go;
    logic if_id_go;
    logic id_exe_go;
    logic exe_mem_go;
    logic mem_wb_go;
    logic if_id_clear;
    logic id_exe_clear;
  } ctrl_t;

  // Whole pipeline frozen.
  localparam ctrl_t CTRL_STALL   = ctrl_t'(7'b00000_00);
  // Normal advance.
  localparam ctrl_t CTRL_ADVANCE = ctrl_t'(7'b11111_00);
  // Taken branch: advance, but squash the two wrong-path instructions.
  localparam ctrl_t CTRL_FLUSH   = ctrl_t'(7'b11111_11);
  // Load-use: hold PC and IF_ID, inject a bubble into ID_EXE.
  localparam ctrl_t CTRL_BUBBLE  = ctrl_t'(7'b00111_01);

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
//   Combinational load-use hazard detector. Flags when the instruction in
//   EXE is a load whose (non-zero) destination is read by the ID instruction.
//   Ports:
//     id_rs, id_rt           source registers of the ID instruction
//     id_uses_rs, id_uses_rt ID instruction actually reads rs / rt
//     exe_mem_read           EXE instruction is a load
//     exe_rd                 destination register of the EXE instruction
//     load_use               hazard flag
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] exe_rd,
  output logic             load_use
);

  logic [REG_W-1:0] src_reg [2];
  logic [1:0]       uses;
  logic [1:0]       hit;

  assign src_reg[0] = id_rs;
  assign src_reg[1] = id_rt;
  assign uses       = {id_uses_rt, id_uses_rs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign hit[gi] = uses[gi] && (src_reg[gi] == exe_rd);
    end
  endgenerate

  // $zero is never a real dependency.
  assign load_use = exe_mem_read && (exe_rd != '0) && (|hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central stall/flush controller for the 5-stage pipeline. Drives the load
//   enables (go) and bubble inserts (clear) of the PC and the four pipeline
//   buffers, sequences multi-cycle memory waits, load-use bubbles, taken-branch
//   flushes and syscall halt/resume, and keeps stall/flush statistics.
//   Parameter:
//     MEM_LATENCY  extra cycles each data-memory access holds MEM (0..15)
//   Ports:
//     clk, rst_n                clock, async active-low reset
//     id_rs/id_rt/id_uses_*     ID instruction operands
//     exe_mem_read, exe_rd      EXE instruction load info
//     branch_taken, halt        EXE control events
//     mem_access                load/store in MEM this cycle
//     resume                    console resume level (edge-detected here)
//     *_go, *_clear             buffer controls (combinational, zero latency)
//     halted                    FSM is in HALTED
//     stall_cycles, flush_count statistics (wrap modulo 2^32)
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] exe_rd,
  input  logic             branch_taken,
  input  logic             halt,
  input  logic             mem_access,
  input  logic             resume,
  output logic             pc_go,
  output logic             if_id_go,
  output logic             id_exe_go,
  output logic             exe_mem_go,
  output logic             mem_wb_go,
  output logic             if_id_clear,
  output logic             id_exe_clear,
  output logic             exe_mem_clear,
  output logic             mem_wb_clear,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam bit               HAS_LATENCY = (MEM_LATENCY > 0);
  localparam logic [WAIT_W-1:0] WAIT_INIT  =
    HAS_LATENCY ? WAIT_W'(MEM_LATENCY - 1) : '0;

  state_t            state_reg,     state_next;
  logic [WAIT_W-1:0] wait_cnt_reg,  wait_cnt_next;
  logic              resume_q_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  flush_cnt_reg;

  logic  load_use;
  logic  resume_rise;
  logic  run_eval;
  logic  mask_mem;
  logic  mask_halt;
  logic  flush_hit;
  ctrl_t ctrl;
  ctrl_t ctrl_gated;

  load_use_detect u_load_use (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .exe_mem_read (exe_mem_read),
    .exe_rd       (exe_rd),
    .load_use     (load_use)
  );

  assign resume_rise = resume && !resume_q_reg;

  // State decode picks whether the priority evaluation runs this cycle and
  // which inputs it must ignore; the priority mux below is shared by RUN,
  // the MEM_WAIT release cycle and the HALTED resume cycle.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    ctrl          = CTRL_STALL;
    flush_hit     = 1'b0;
    run_eval      = 1'b0;
    mask_mem      = 1'b0;
    mask_halt     = 1'b0;

    case (state_reg)
      RUN: run_eval = 1'b1;
      MEM_WAIT: begin
        if (wait_cnt_reg != '0) begin
          wait_cnt_next = wait_cnt_reg - 1'b1;
        end else begin
          // The access already paid its latency; don't restart it.
          run_eval = 1'b1;
          mask_mem = 1'b1;
        end
      end
      HALTED: begin
        if (resume_rise) begin
          // The halting syscall is still in EXE; let it pass this time.
          run_eval  = 1'b1;
          mask_halt = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase

    if (run_eval) begin
      state_next = RUN;
      if (HAS_LATENCY && mem_access && !mask_mem) begin
        state_next    = MEM_WAIT;
        wait_cnt_next = WAIT_INIT;
      end else if (halt && !mask_halt) begin
        state_next = HALTED;
      end else if (branch_taken) begin
        ctrl      = CTRL_FLUSH;
        flush_hit = 1'b1;
      end else if (load_use) begin
        ctrl = CTRL_BUBBLE;
      end else begin
        ctrl = CTRL_ADVANCE;
      end
    end
  end

  // Outputs are forced quiet for as long as reset is held, not just from the
  // next edge on.
  assign ctrl_gated    = rst_n ? ctrl : CTRL_STALL;
  assign pc_go         = ctrl_gated.pc_go;
  assign if_id_go      = ctrl_gated.if_id_go;
  assign id_exe_go     = ctrl_gated.id_exe_go;
  assign exe_mem_go    = ctrl_gated.exe_mem_go;
  assign mem_wb_go     = ctrl_gated.mem_wb_go;
  assign if_id_clear   = ctrl_gated.if_id_clear;
  assign id_exe_clear  = ctrl_gated.id_exe_clear;
  assign exe_mem_clear = 1'b0;
  assign mem_wb_clear  = 1'b0;
  assign halted        = (state_reg == HALTED);
  assign stall_cycles  = stall_cnt_reg;
  assign flush_count   = flush_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      resume_q_reg  <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      resume_q_reg <= resume;
      if (!ctrl.pc_go) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (flush_hit) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Scoreboard bench for pipeline_ctrl (MEM_LATENCY=3). A driver applies one
//   stimulus per cycle shortly after the rising edge, runs a cycle-level
//   reference model and queues the expected outputs; a monitor on the falling
//   edge pops and compares. Directed scenarios come first, then random traffic.
module tb_pipeline_ctrl;

  localparam int LAT = 3;

  // go/clear vector order: pc, if_id, id_exe, exe_mem, mem_wb go;
  // if_id, id_exe, exe_mem, mem_wb clear
  localparam logic [8:0] V_STALL = 9'b00000_0000;
  localparam logic [8:0] V_ADV   = 9'b11111_0000;
  localparam logic [8:0] V_FLUSH = 9'b11111_1100;
  localparam logic [8:0] V_BUB   = 9'b00111_0100;

  typedef struct {
    bit         rst_n;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    bit         uses_rs;
    bit         uses_rt;
    bit         mem_read;
    logic [4:0] exe_rd;
    bit         branch;
    bit         halt;
    bit         mem_access;
    bit         resume;
  } stim_t;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic        halted;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, exe_rd;
  logic        id_uses_rs, id_uses_rt, exe_mem_read;
  logic        branch_taken, halt, mem_access, resume;
  logic        pc_go, if_id_go, id_exe_go, exe_mem_go, mem_wb_go;
  logic        if_id_clear, id_exe_clear, exe_mem_clear, mem_wb_clear;
  logic        halted;
  logic [31:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  exp_t sb_q[$];

  // Reference model state: time-based memory window, halt flag, counters.
  longint      m_now       = 0;
  bit          m_in_mem    = 0;
  longint      m_mem_end   = 0;
  bit          m_halted    = 0;
  bit          m_prev_res  = 0;
  logic [31:0] m_stall     = 0;
  logic [31:0] m_flush     = 0;
  bit          last_resume = 0;

  pipeline_ctrl #(.MEM_LATENCY(LAT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .exe_mem_read  (exe_mem_read),
    .exe_rd        (exe_rd),
    .branch_taken  (branch_taken),
    .halt          (halt),
    .mem_access    (mem_access),
    .resume        (resume),
    .pc_go         (pc_go),
    .if_id_go      (if_id_go),
    .id_exe_go     (id_exe_go),
    .exe_mem_go    (exe_mem_go),
    .mem_wb_go     (mem_wb_go),
    .if_id_clear   (if_id_clear),
    .id_exe_clear  (id_exe_clear),
    .exe_mem_clear (exe_mem_clear),
    .mem_wb_clear  (mem_wb_clear),
    .halted        (halted),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1; s.id_rs = 0; s.id_rt = 0; s.uses_rs = 0; s.uses_rt = 0;
    s.mem_read = 0; s.exe_rd = 0; s.branch = 0; s.halt = 0;
    s.mem_access = 0; s.resume = 0;
    return s;
  endfunction

  function automatic stim_t rand_stim(input bit allow_reset, input bit prev_res);
    stim_t s;
    s.rst_n      = allow_reset ? ($urandom_range(0, 199) != 0) : 1'b1;
    s.id_rs      = 5'($urandom_range(0, 3));
    s.id_rt      = 5'($urandom_range(0, 3));
    s.uses_rs    = ($urandom_range(0, 1) == 1);
    s.uses_rt    = ($urandom_range(0, 1) == 1);
    s.mem_read   = ($urandom_range(0, 2) == 0);
    s.exe_rd     = 5'($urandom_range(0, 3));
    s.branch     = ($urandom_range(0, 5) == 0);
    s.halt       = ($urandom_range(0, 24) == 0);
    s.mem_access = ($urandom_range(0, 7) == 0);
    s.resume     = prev_res ^ ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  // One model cycle: returns outputs visible during this cycle, then advances.
  function automatic exp_t model_step(input stim_t s);
    exp_t e;
    bit   lu, rise, do_eval, no_mem, no_halt;
    e.ctrl   = V_STALL;
    e.halted = 1'b0;
    if (!s.rst_n) begin
      m_stall = 0; m_flush = 0; m_halted = 0; m_in_mem = 0; m_prev_res = 0;
      e.stall = 0; e.flush = 0;
      m_now++;
      return e;
    end
    e.stall  = m_stall;
    e.flush  = m_flush;
    e.halted = m_halted;
    lu = s.mem_read && (s.exe_rd != 0) &&
         ((s.uses_rs && s.id_rs == s.exe_rd) || (s.uses_rt && s.id_rt == s.exe_rd));
    rise    = s.resume && !m_prev_res;
    do_eval = 0; no_mem = 0; no_halt = 0;
    if (m_in_mem) begin
      if (m_now >= m_mem_end) begin do_eval = 1; no_mem = 1; end
    end else if (m_halted) begin
      if (rise) begin do_eval = 1; no_halt = 1; end
    end else begin
      do_eval = 1;
    end
    if (do_eval) begin
      m_in_mem = 0;
      m_halted = 0;
      if (s.mem_access && !no_mem) begin
        m_in_mem  = 1;
        m_mem_end = m_now + LAT;   // stalled on cycles now .. now+LAT-1
      end else if (s.halt && !no_halt) begin
        m_halted = 1;
      end else if (s.branch) begin
        e.ctrl = V_FLUSH;
        m_flush++;
      end else if (lu) begin
        e.ctrl = V_BUB;
      end else begin
        e.ctrl = V_ADV;
      end
    end
    if (!e.ctrl[8]) m_stall++;
    m_prev_res = s.resume;
    m_now++;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    rst_n        = s.rst_n;
    id_rs        = s.id_rs;
    id_rt        = s.id_rt;
    id_uses_rs   = s.uses_rs;
    id_uses_rt   = s.uses_rt;
    exe_mem_read = s.mem_read;
    exe_rd       = s.exe_rd;
    branch_taken = s.branch;
    halt         = s.halt;
    mem_access   = s.mem_access;
    resume       = s.resume;
    last_resume  = s.resume;
    sb_q.push_back(model_step(s));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e   = sb_q.pop_front();
      act = {pc_go, if_id_go, id_exe_go, exe_mem_go, mem_wb_go,
             if_id_clear, id_exe_clear, exe_mem_clear, mem_wb_clear};
      check("ctrl",         32'(act),          32'(e.ctrl));
      check("halted",       32'(halted),       32'(e.halted));
      check("stall_cycles", stall_cycles,      e.stall);
      check("flush_count",  flush_count,       e.flush);
      $display("cyc %0d rst_n=%b ctrl=%b halted=%b stall=%0d flush=%0d",
               cyc, rst_n, act, halted, stall_cycles, flush_count);
      cyc++;
    end
  end

  initial begin
    stim_t s;
    rst_n = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    exe_mem_read = 0; exe_rd = 0; branch_taken = 0; halt = 0;
    mem_access = 0; resume = 0;

    // Reset held with random inputs, then idle advance.
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(1'b0, last_resume);
      s.rst_n = 0;
      drive(s);
    end
    repeat (2) drive(idle());

    // Load-use on rs, then the bubble clears it; exe_rd=0 never stalls.
    s = idle(); s.mem_read = 1; s.exe_rd = 5; s.id_rs = 5; s.uses_rs = 1;
    drive(s);
    drive(idle());
    s.exe_rd = 0; s.id_rs = 0;
    drive(s);

    // Branch and load-use together: flush wins.
    s = idle(); s.mem_read = 1; s.exe_rd = 7; s.id_rt = 7; s.uses_rt = 1; s.branch = 1;
    drive(s);
    drive(idle());

    // Memory access held for LAT+1 cycles.
    s = idle(); s.mem_access = 1;
    repeat (LAT + 1) drive(s);
    drive(idle());

    // Halt with resume already high, then a fresh edge with halt still present.
    s = idle(); s.resume = 1; drive(s);
    s.halt = 1; drive(s);
    s.halt = 0; repeat (3) drive(s);
    s.resume = 0; drive(s);
    s.resume = 1; s.halt = 1; drive(s);
    s.halt = 0; drive(s);
    drive(idle());

    // Reset asserted while two wait cycles remain.
    s = idle(); s.mem_access = 1; drive(s);
    s = idle(); s.rst_n = 0; drive(s);
    drive(s);
    repeat (2) drive(idle());

    // Random traffic with occasional reset.
    for (int i = 0; i < 2000; i++) begin
      drive(rand_stim(1'b1, last_resume));
    end

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
